// File: rtl/iis_rx.sv
// iis_rx: slave-mode I2S (Philips format) receiver.
//
// Samples the externally driven SCK/WS/SD pins in the clk_i domain. Each
// SCK rising edge shifts one bit into a left-justified word. A WS change
// marks the LSB of the word belonging to the previous WS level. Completed
// words go into a first-word-fall-through FIFO that is read as a stream.
//
// Ports:
//   clk_i, rst_i         system clock (>= 8x SCK), async active-high reset
//   en_i                 receiver enable; dropping it aborts the partial word
//   flush_i              one-cycle FIFO clear (ovf_o is not touched)
//   ovf_clr_i            clears sticky ovf_o
//   thr_i                level interrupt threshold (0 disables irq_o)
//   sck_i, ws_i, sd_i    asynchronous I2S pins (ws 0 = left, 1 = right)
//   rdata_o, rch_o       head-of-FIFO sample and its channel
//   valid_o, ready_i     output stream handshake
//   level_o              FIFO occupancy, 0..FIFO_DEPTH
//   ovf_o                sticky: a word arrived while the FIFO was full
//   irq_o                registered (level_o >= thr_i) & (thr_i != 0)
//
// Stream handshake: rdata_o/rch_o are valid whenever valid_o is 1 and stay
// stable until accepted. A word is consumed on every clk_i edge where
// valid_o & ready_i. ready_i may be asserted without valid_o; it is ignored.
module iis_rx #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              flush_i,
    input  logic              ovf_clr_i,
    input  logic [LVL_W-1:0]  thr_i,
    input  logic              sck_i,
    input  logic              ws_i,
    input  logic              sd_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rch_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [LVL_W-1:0]  level_o,
    output logic              ovf_o,
    output logic              irq_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  BIT_MAX = CNT_W'(DATA_W);
    localparam logic [LVL_W-1:0]  LVL_MAX = LVL_W'(FIFO_DEPTH);
    localparam logic [DATA_W-1:0] MSB_ONE = {1'b1, {(DATA_W-1){1'b0}}};

    // ---------------- pin synchronisers ----------------
    // sck_q[1] is the synchronised SCK, sck_q[2] its delayed copy for edge detect.
    logic [2:0] sck_q;
    logic [1:0] ws_q;
    logic [1:0] sd_q;
    logic       sck_re;
    logic       ws_s;
    logic       sd_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_q <= '0;
            ws_q  <= '0;
            sd_q  <= '0;
        end else begin
            sck_q <= {sck_q[1:0], sck_i};
            ws_q  <= {ws_q[0], ws_i};
            sd_q  <= {sd_q[0], sd_i};
        end
    end

    assign sck_re = sck_q[1] & ~sck_q[2];
    assign ws_s   = ws_q[1];
    assign sd_s   = sd_q[1];

    // ---------------- word assembly FSM ----------------
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] sr, sr_nxt, sr_ins;
    logic [CNT_W-1:0]  bitcnt, bitcnt_nxt;
    logic              ws_prev, ws_prev_nxt;
    logic              push, push_nxt;
    logic [DATA_W:0]   push_word, push_word_nxt;

    // sr only ever has zeros below the current bit position, so OR-ing the
    // shifted marker places sd at sr[DATA_W-1-bitcnt]. Once bitcnt reaches
    // DATA_W the shift yields zero and further bits are truncated.
    assign sr_ins = sd_s ? (sr | (MSB_ONE >> bitcnt)) : sr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            sr        <= '0;
            bitcnt    <= '0;
            ws_prev   <= 1'b0;
            push      <= 1'b0;
            push_word <= '0;
        end else begin
            state     <= state_nxt;
            sr        <= sr_nxt;
            bitcnt    <= bitcnt_nxt;
            ws_prev   <= ws_prev_nxt;
            push      <= push_nxt;
            push_word <= push_word_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sr_nxt        = sr;
        bitcnt_nxt    = bitcnt;
        ws_prev_nxt   = ws_prev;
        push_nxt      = 1'b0;
        push_word_nxt = push_word;
        unique case (state)
            IDLE: begin
                sr_nxt     = '0;
                bitcnt_nxt = '0;
                if (sck_re) begin
                    ws_prev_nxt = ws_s;
                    // The edge that reveals the WS change carries the LSB of a
                    // word whose start was missed, so it is dropped.
                    if (en_i && (ws_s != ws_prev)) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (!en_i) begin
                    state_nxt  = IDLE;
                    sr_nxt     = '0;
                    bitcnt_nxt = '0;
                end else if (sck_re) begin
                    if (ws_s == ws_prev) begin
                        sr_nxt = sr_ins;
                        if (bitcnt != BIT_MAX) begin
                            bitcnt_nxt = bitcnt + CNT_W'(1);
                        end
                    end else begin
                        push_nxt      = 1'b1;
                        push_word_nxt = {ws_prev, sr_ins};
                        sr_nxt        = '0;
                        bitcnt_nxt    = '0;
                        ws_prev_nxt   = ws_s;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- output FIFO ----------------
    logic [DATA_W:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] count;
    logic             full, do_pop, do_push;

    assign valid_o = (count != '0);
    assign full    = (count == LVL_MAX);
    assign do_pop  = valid_o & ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata_o = mem[rd_ptr][DATA_W-1:0];
    assign rch_o   = mem[rd_ptr][DATA_W];
    assign level_o = count;

    // ---------------- overflow and interrupt ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_o <= 1'b0;
            irq_o <= 1'b0;
        end else begin
            if (push & full & ~do_pop & ~flush_i) begin
                ovf_o <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_o <= 1'b0;
            end
            irq_o <= (count >= thr_i) && (thr_i != '0);
        end
    end

endmodule

// File: tb/tb_iis_rx.sv
module tb_iis_rx;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int LW    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [LW-1:0] thr = '0;
  logic          sck = 1'b0;
  logic          ws = 1'b0;
  logic          sd = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] rdata;
  logic          rch;
  logic          valid;
  logic [LW-1:0] level;
  logic          ovf;
  logic          irq;

  iis_rx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .LVL_W(LW)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush), .ovf_clr_i(ovf_clr),
    .thr_i(thr), .sck_i(sck), .ws_i(ws), .sd_i(sd),
    .rdata_o(rdata), .rch_o(rch), .valid_o(valid), .ready_i(ready),
    .level_o(level), .ovf_o(ovf), .irq_o(irq)
  );

  // ---------------- scoreboard ----------------
  logic [DW:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  logic cur_ch = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the slot value is left-justified into DW bits; a longer slot
  // loses its low bits, a shorter one gets zero LSBs.
  function automatic logic [DW:0] model_word(input logic ch, input int n, input logic [31:0] v);
    longint unsigned x;
    x = longint'(v) & ((64'd1 << n) - 64'd1);
    if (n >= DW) x = x >> (n - DW);
    else x = x << (DW - n);
    return {ch, x[DW-1:0]};
  endfunction

  // Monitor: every accepted beat is compared against the queue head.
  initial begin
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stream_unexpected: got ch=%0d data=%h with nothing expected", rch, rdata);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if ({rch, rdata} !== e) begin
            failures++;
            $display("FAIL stream_word: got ch=%0d data=%h expected ch=%0d data=%h", rch, rdata, e[DW], e[DW-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+1. One SCK period = 16 clk; the rising edge
  // is mid-bit. mode 1: check valid latency; mode 2: pop during the push cycle.
  task automatic send_bit(input logic w, input logic d, input int mode);
    ws = w; sd = d; sck = 1'b0;
    repeat (8) @(posedge clk);
    #1 sck = 1'b1;
    if (mode == 1) begin
      repeat (3) @(posedge clk);
      #1 check("latency_valid_low_3clk", valid, 1'b0);
      @(posedge clk);
      #1 check("latency_valid_high_4clk", valid, 1'b1);
      repeat (4) @(posedge clk);
      #1;
    end else if (mode == 2) begin
      repeat (3) @(posedge clk);
      #1 ready = 1'b1;
      @(posedge clk);
      #1 ready = 1'b0;
      check("full_pushpop_level", level, exp_q.size());
      check("full_pushpop_ovf", ovf, 1'b0);
      repeat (4) @(posedge clk);
      #1;
    end else begin
      repeat (8) @(posedge clk);
      #1;
    end
    sck = 1'b0;
  endtask

  // Philips framing: WS already shows the next channel during the LSB.
  task automatic send_bits(input logic ch, input logic [31:0] v, input int hi, input int lo, input int mode);
    for (int i = hi; i >= lo; i--) begin
      send_bit((i == 0) ? ~ch : ch, v[i], (i == 0) ? mode : 0);
    end
    if (lo == 0) cur_ch = ~ch;
  endtask

  task automatic send_next(input int n, input logic [31:0] v, input bit keep, input int mode);
    if (keep) exp_q.push_back(model_word(cur_ch, n, v));
    send_bits(cur_ch, v, n - 1, 0, mode);
  endtask

  // Disable, let the receiver see WS=1, enable, then send one right word
  // that is never delivered (its start predates the first WS change).
  task automatic start_session();
    en = 1'b0;
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1 en = 1'b1;
    cur_ch = 1'b1;
    send_next(16, $urandom, 1'b0, 0);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    ready = 1'b1;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      #1 t++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 check({name, "_valid_low"}, valid, 1'b0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_rdata"}, rdata, '0);
    check({name, "_rch"}, rch, 1'b0);
    check({name, "_valid"}, valid, 1'b0);
    check({name, "_level"}, level, '0);
    check({name, "_ovf"}, ovf, 1'b0);
    check({name, "_irq"}, irq, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    repeat (95000) @(posedge clk);
    failures++;
    $display("FAIL watchdog: run did not complete within cycle budget");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] v;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Three L/R frames of fixed patterns; first full word is checked for latency.
    ready = 1'b1;
    start_session();
    for (int f = 0; f < 3; f++) begin
      send_next(16, 32'hA5A5, 1'b1, (f == 0) ? 1 : 0);
      send_next(16, 32'h5A5A, 1'b1, 0);
    end
    drain("frames");

    // Truncation, short slots, then random slot widths and data.
    send_next(24, 32'h123456, 1'b1, 0);
    send_next(24, 32'h123456, 1'b1, 0);
    send_next(8, 32'hC3, 1'b1, 0);
    send_next(8, 32'hC3, 1'b1, 0);
    for (int i = 0; i < 8; i++) begin
      send_next($urandom_range(8, 32), $urandom, 1'b1, 0);
    end
    drain("widths");

    // Overflow: ten words with no consumer, only the first eight survive.
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send_next(16, $urandom, (i < DEPTH), 0);
    end
    check("ovf_level", level, exp_q.size());
    check("ovf_set", ovf, 1'b1);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 1'b0);

    // Full FIFO with a pop in the push cycle: nothing lost.
    send_next(16, $urandom, 1'b1, 2);
    drain("full_pushpop");

    // Level interrupt and flush.
    ready = 1'b0;
    thr = LW'(3);
    repeat (2) @(posedge clk);
    #1 check("irq_level0", irq, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      send_next(16, $urandom, 1'b1, 0);
      check("irq_level", level, exp_q.size());
      check("irq_thr3", irq, (exp_q.size() >= 3));
    end
    thr = '0;
    repeat (2) @(posedge clk);
    #1 check("irq_thr0", irq, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_level", level, '0);
    check("flush_valid", valid, 1'b0);
    exp_q.delete();
    thr = LW'(3);

    // Reset in the middle of a left word, then resume the same stream.
    ready = 1'b1;
    if (cur_ch) send_next(16, $urandom, 1'b1, 0);
    drain("pre_reset");
    v = $urandom;
    send_bits(1'b0, v, 15, 8, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 check_idle_outputs("mid_reset");
    rst = 1'b0;
    send_bits(1'b0, v, 7, 0, 0);
    for (int i = 0; i < 4; i++) begin
      send_next(16, $urandom, 1'b1, 0);
    end
    drain("after_reset");

    // Drop enable mid-word: no push, FIFO contents kept.
    ready = 1'b0;
    send_next(16, $urandom, 1'b1, 0);
    v = $urandom;
    send_bits(cur_ch, v, 15, 9, 0);
    repeat (2) @(posedge clk);
    #1 en = 1'b0;
    send_bits(cur_ch, v, 8, 0, 0);
    check("en_drop_level", level, exp_q.size());
    check("en_drop_valid", valid, 1'b1);
    start_session();
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_next($urandom_range(8, 32), $urandom, 1'b1, 0);
    end
    drain("after_en_drop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iis_rx.md
Name: iis_rx

Overview:
- Slave-mode I2S (Philips format) receiver, the receive-direction counterpart of the team's APB I2S transmit peripheral.
- Samples externally driven SCK/WS/SD pins in the clk_i domain and assembles per-channel audio words.
- Buffers the words in a small FIFO and presents them on a valid/ready stream with level interrupt and sticky overflow.
- An APB register wrapper inside the user plugin instantiates it.

Parameters:
- DATA_W, 16, stored sample width in bits (8..32)
- FIFO_DEPTH, 8, FIFO entries (power of two, >=2)
- LVL_W, 4, width of level and threshold (= log2(FIFO_DEPTH)+1)

Ports:
- clk_i  in  1  system clock; must be >= 8x SCK frequency
- rst_i  in  1  asynchronous, active-high reset
- en_i  in  1  receiver enable
- flush_i  in  1  synchronous FIFO clear, one-cycle pulse
- ovf_clr_i  in  1  clears ovf_o
- thr_i  in  LVL_W  interrupt threshold
- sck_i  in  1  I2S bit clock (async)
- ws_i  in  1  I2S word select (async); 0 = left, 1 = right
- sd_i  in  1  I2S serial data (async)
- rdata_o  out  DATA_W  head-of-FIFO sample
- rch_o  out  1  channel of rdata_o (0 = left, 1 = right)
- valid_o  out  1  FIFO not empty
- ready_i  in  1  consumer pop
- level_o  out  LVL_W  FIFO occupancy
- ovf_o  out  1  sticky overflow
- irq_o  out  1  level interrupt

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM in IDLE; sync flops 0.

Input synchronisation:
- sck_i, ws_i and sd_i each pass through 2-flop synchronisers.
- A 3rd sck flop provides rising-edge detect (sck_re = s2 & ~s3).
- All bit actions below occur in the clk_i cycle where sck_re = 1, using synced ws/sd.

FSM IDLE:
- Entered on reset, or whenever en_i = 0.
- Clears the shift register and bit count.
- Loads ws_prev from synced ws on every sck_re.
- Goes to RUN on the first sck_re where ws != ws_prev. The bit sampled at that edge is discarded, so the first partial word is never delivered.

FSM RUN, on sck_re:
- If ws == ws_prev: if bitcnt < DATA_W, write sd into sr[DATA_W-1-bitcnt]. bitcnt increments, saturating at DATA_W. Bits beyond DATA_W are dropped (truncation).
- If ws != ws_prev: this bit is the LSB of the current word. Insert it as above, then push {ws_prev, word} to the FIFO. Clear sr and bitcnt, and set ws_prev = ws.
- Words shorter than DATA_W are left-justified, with the unreceived LSBs = 0.

en_i:
- Falling en_i aborts the partial word without a push.
- FIFO contents are kept.

FIFO:
- First-word fall-through: rdata_o/rch_o are valid whenever valid_o = 1.
- Pop occurs when valid_o & ready_i.
- Push when full, without a same-cycle pop: the word is dropped and ovf_o is set.
- Push and pop in the same cycle when full: both succeed, level is unchanged, no overflow.
- Push and pop in the same cycle when empty: the push succeeds, the pop is ignored because valid_o = 0.
- level_o counts 0..FIFO_DEPTH.
- flush_i empties the FIFO the next cycle. It has priority over a same-cycle push and pop. It does not clear ovf_o.

ovf_o:
- Cleared by ovf_clr_i.
- If set and clear occur in the same cycle, set wins.

irq_o:
- Registered: (level >= thr_i) & (thr_i != 0), updated each cycle.

Latency:
- valid_o rises 4 clk_i cycles after the SCK rising pin edge that carries the LSB (2 sync + 1 detect/push + 1 FIFO flag register).

Test Plan:
- Enable. Send 3 frames of L = 0xA5A5, R = 0x5A5A, 16-bit slots, SCK = clk/16 -> first partial word discarded; FIFO then holds (L, 0xA5A5), (R, 0x5A5A), …; valid_o is 4 clk after the LSB edge.
- 24-bit slots carrying 0x123456, DATA_W = 16 -> rdata_o = 0x1234. 8-bit slots carrying 0xC3 -> rdata_o = 0xC300.
- ready_i = 0 while 10 words arrive (DEPTH = 8) -> level_o = 8, ovf_o = 1, the first 8 words are retained in order. Then pulse ovf_clr_i -> ovf_o = 0.
- FIFO full, with ready_i = 1 held during the LSB push cycle -> level stays 8, ovf_o stays 0, the order is continuous.
- thr_i = 3 -> irq_o = 0 at levels 0–2, 1 from level 3; thr_i = 0 -> irq_o = 0 always. flush_i at level 5 -> level_o = 0, valid_o = 0 next cycle.
- Assert rst_i mid-word, release, then continue the stream -> all outputs 0 and IDLE; the next full word after a WS transition is received correctly. Dropping en_i mid-word -> no push, FIFO unchanged.
